branch_hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage branch-stall logic.
- Replaces the fixed E/M register-compare hazard checks with a per-register latency scoreboard. Each scoreboard entry counts down the cycles until its result can be forwarded to decode.
- Produces a branch stall and a load-use stall for any producer latency.
- Supports E-stage squash and a saturating stall performance counter.
- Sits in the decode stage, between the register-file read and the hazard/forwarding mux control.

---
 rtl/branch_hazard_scoreboard.sv | 90 +++++++++
 tb/tb_branch_hazard_scoreboard.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_hazard_scoreboard.sv
// rtl/branch_hazard_scoreboard.sv - decode-stage per-register latency scoreboard for branch and load-use stalls
module branch_hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  parameter int EX_SLACK = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [AW-1:0]     issue_wr,
  input  logic              issue_is_load,
  input  logic              flush_e,
  input  logic [AW-1:0]     rs_d,
  input  logic [AW-1:0]     rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              branch_d,
  output logic              stall,
  output logic              stall_branch,
  output logic              stall_load_use,
  output logic [PERF_W-1:0] stall_count
);

  localparam int MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] ALU_C   = CW'(ALU_LAT);
  localparam logic [CW-1:0] LOAD_C  = CW'(LOAD_LAT);
  localparam logic [CW-1:0] SLACK_C = CW'(EX_SLACK);

  logic [CW-1:0]     cnt_q [NREG];
  logic [CW-1:0]     cnt_d [NREG];
  logic              e_valid_q, e_valid_d;
  logic [AW-1:0]     e_reg_q, e_reg_d;
  logic [PERF_W-1:0] stall_count_q, stall_count_d;
  logic              iss;

  // Branches resolve in D and need the value fully produced; other consumers get EX_SLACK from E forwarding.
  assign stall_branch   = branch_d &
                          ((use_rs_d & (cnt_q[rs_d] != '0)) | (use_rt_d & (cnt_q[rt_d] != '0)));
  assign stall_load_use = ~branch_d &
                          ((use_rs_d & (cnt_q[rs_d] > SLACK_C)) | (use_rt_d & (cnt_q[rt_d] > SLACK_C)));
  assign stall          = stall_branch | stall_load_use;
  assign iss            = issue_valid & ~stall & issue_we & (issue_wr != '0);
  assign stall_count    = stall_count_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (iss && (issue_wr == AW'(r))) begin
        cnt_d[r] = issue_is_load ? LOAD_C : ALU_C;
      end else if (flush_e && e_valid_q && (e_reg_q == AW'(r))) begin
        cnt_d[r] = '0;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
    end
    // E advances every cycle, so the record only ever describes last cycle's issue.
    e_valid_d     = iss;
    e_reg_d       = iss ? issue_wr : '0;
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      e_valid_q     <= 1'b0;
      e_reg_q       <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      e_valid_q     <= e_valid_d;
      e_reg_q       <= e_reg_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_branch_hazard_scoreboard.sv
// tb/tb_branch_hazard_scoreboard.sv - self-checking bench for branch_hazard_scoreboard
module tb_branch_hazard_scoreboard;

  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int EX_SLACK = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue_valid, issue_we, issue_is_load, flush_e;
  logic [4:0]  issue_wr, rs_d, rt_d;
  logic        use_rs_d, use_rt_d, branch_d;
  logic        stall, stall_branch, stall_load_use;
  logic [15:0] stall_count;
  logic        s_stall, s_stall_branch, s_stall_load_use;
  logic [2:0]  s_stall_count;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready_b [32];
  logic       e_valid;
  logic [4:0] e_reg;
  int mcnt, mcnt_sat;

  always #5 clk = ~clk;

  branch_hazard_scoreboard u_dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_wr(issue_wr), .issue_is_load(issue_is_load), .flush_e(flush_e),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .branch_d(branch_d),
    .stall(stall), .stall_branch(stall_branch), .stall_load_use(stall_load_use),
    .stall_count(stall_count)
  );

  branch_hazard_scoreboard #(.PERF_W(3)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_wr(issue_wr), .issue_is_load(issue_is_load), .flush_e(flush_e),
    .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d), .branch_d(branch_d),
    .stall(s_stall), .stall_branch(s_stall_branch), .stall_load_use(s_stall_load_use),
    .stall_count(s_stall_count)
  );

  // Reference: each register records the first cycle in which a branch may read it.
  function automatic logic m_busy_b(logic [4:0] r);
    return (r != 0) && (cyc < ready_b[r]);
  endfunction

  function automatic logic m_busy_n(logic [4:0] r);
    return (r != 0) && (cyc < ready_b[r] - EX_SLACK);
  endfunction

  function automatic logic exp_sb();
    return branch_d && ((use_rs_d && m_busy_b(rs_d)) || (use_rt_d && m_busy_b(rt_d)));
  endfunction

  function automatic logic exp_sl();
    return !branch_d && ((use_rs_d && m_busy_n(rs_d)) || (use_rt_d && m_busy_n(rt_d)));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ready_b[i] = 0;
    e_valid = 1'b0;
    e_reg = '0;
    mcnt = 0;
    mcnt_sat = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_wr = 0; issue_is_load = 0; flush_e = 0;
    rs_d = 0; rt_d = 0; use_rs_d = 0; use_rt_d = 0; branch_d = 0;
  endtask

  task automatic tick();
    logic st, iss;
    st = exp_sb() || exp_sl();
    iss = issue_valid && !st && issue_we && (issue_wr != 0);
    if (flush_e && e_valid && !(iss && issue_wr == e_reg)) ready_b[e_reg] = cyc + 1;
    if (iss) ready_b[issue_wr] = cyc + 1 + (issue_is_load ? LOAD_LAT : ALU_LAT);
    if (st) begin
      if (mcnt < 65535) mcnt++;
      if (mcnt_sat < 7) mcnt_sat++;
    end
    e_valid = iss;
    e_reg = issue_wr;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 0;
    idle();
    model_clear();
    @(posedge clk);
    cyc++;
    #1;
    reset_n = 1;
    #1;
  endtask

  task automatic issue(input logic [4:0] r, input logic ld);
    issue_valid = 1; issue_we = 1; issue_wr = r; issue_is_load = ld;
  endtask

  task automatic test_reset();
    idle();
    #1;
    reset_n = 0;
    branch_d = 1; rs_d = 3; use_rs_d = 1;
    model_clear();
    repeat (2) @(posedge clk);
    cyc += 2;
    #2;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_cmp++;
    if (stall_count !== 16'd0 || s_stall_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d/%0d exp=0/0", stall_count, s_stall_count);
    end
    reset_n = 1;
    #2;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall got=%b exp=0", stall); end
    idle();
    tick();
  endtask

  task automatic test_alu_branch();
    idle(); issue(5, 0);
    tick();
    idle(); branch_d = 1; rs_d = 5; use_rs_d = 1;
    #2;
    n_cmp++;
    if (stall_branch !== 1'b1 || stall !== 1'b1) begin
      n_fail++; $display("FAIL alu_branch_stall got=%b/%b exp=1/1", stall_branch, stall);
    end
    tick();
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_branch_release got=%b exp=0", stall); end
    n_cmp++;
    if (stall_count !== 16'd1) begin n_fail++; $display("FAIL alu_branch_count got=%0d exp=1", stall_count); end
    idle(); tick();
  endtask

  task automatic test_load();
    logic [2:0] seen;
    idle(); issue(7, 1);
    tick();
    idle(); branch_d = 1; rt_d = 7; use_rt_d = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      seen[i] = stall_branch;
      tick();
    end
    n_cmp++;
    if (seen !== 3'b011) begin n_fail++; $display("FAIL load_branch_profile got=%b exp=011", seen); end
    idle(); issue(7, 1);
    tick();
    idle(); rt_d = 7; use_rt_d = 1;
    #1;
    n_cmp++;
    if (stall_load_use !== 1'b1 || stall_branch !== 1'b0) begin
      n_fail++; $display("FAIL load_use_stall got=%b/%b exp=1/0", stall_load_use, stall_branch);
    end
    tick();
    n_cmp++;
    if (stall_load_use !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%b exp=0", stall_load_use); end
    idle(); tick();
  endtask

  task automatic test_r0_unused();
    idle(); issue(0, 1);
    tick();
    idle(); branch_d = 1; rs_d = 0; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL r0_branch got=%b exp=0", stall); end
    idle(); issue(9, 1);
    tick();
    idle(); rt_d = 9; use_rt_d = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_rt_consumer got=%b exp=0", stall); end
    branch_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_rt_branch got=%b exp=0", stall); end
    idle(); repeat (3) tick();
  endtask

  task automatic test_flush_waw();
    idle(); issue(4, 1);
    tick();
    idle(); flush_e = 1;
    tick();
    idle(); branch_d = 1; rs_d = 4; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_clears got=%b exp=0", stall); end
    idle(); issue(4, 1);
    tick();
    issue(4, 0);
    tick();
    idle(); branch_d = 1; rs_d = 4; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", stall); end
    tick();
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL waw_release got=%b exp=0", stall); end
    idle(); issue(4, 1);
    tick();
    issue(4, 0); flush_e = 1;
    tick();
    idle(); branch_d = 1; rs_d = 4; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL issue_beats_flush got=%b exp=1", stall); end
    idle(); repeat (3) tick();
  endtask

  task automatic test_stall_ignores_issue();
    idle(); issue(6, 1);
    tick();
    branch_d = 1; rs_d = 6; use_rs_d = 1; issue(8, 1);
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL stalled_issue_precond got=%b exp=1", stall); end
    tick();
    tick();
    idle(); branch_d = 1; rs_d = 8; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL stalled_issue_ignored got=%b exp=0", stall); end
    idle(); tick();
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      idle(); issue(1, 1);
      tick();
      idle(); branch_d = 1; rs_d = 1; use_rs_d = 1;
      tick();
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if (s_stall_count !== 3'd7) begin n_fail++; $display("FAIL sat_count got=%0d exp=7", s_stall_count); end
    n_cmp++;
    if (stall_count !== 16'd10) begin n_fail++; $display("FAIL wide_count got=%0d exp=10", stall_count); end
    issue(1, 1);
    tick();
    idle(); branch_d = 1; rs_d = 1; use_rs_d = 1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL midreset_precond got=%b exp=1", stall); end
    reset_n = 0;
    #1;
    n_cmp++;
    if (stall !== 1'b0 || s_stall !== 1'b0) begin
      n_fail++; $display("FAIL midreset_stall got=%b/%b exp=0/0", stall, s_stall);
    end
    n_cmp++;
    if (stall_count !== 16'd0 || s_stall_count !== 3'd0) begin
      n_fail++; $display("FAIL midreset_count got=%0d/%0d exp=0/0", stall_count, s_stall_count);
    end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      issue_valid   = ($urandom_range(0, 99) < 60);
      issue_we      = ($urandom_range(0, 9) != 0);
      issue_wr      = 5'($urandom_range(0, 7));
      issue_is_load = 1'($urandom_range(0, 1));
      flush_e       = ($urandom_range(0, 7) == 0);
      rs_d          = 5'($urandom_range(0, 7));
      rt_d          = 5'($urandom_range(0, 7));
      use_rs_d      = 1'($urandom_range(0, 1));
      use_rt_d      = 1'($urandom_range(0, 1));
      branch_d      = ($urandom_range(0, 9) < 4);
      #2;
      n_cmp++;
      if (stall_branch !== exp_sb() || stall_load_use !== exp_sl() || stall !== (exp_sb() | exp_sl())) begin
        n_fail++;
        $display("FAIL rand_stall cyc=%0d got=%b%b%b exp=%b%b%b", i, stall, stall_branch, stall_load_use,
                 exp_sb() | exp_sl(), exp_sb(), exp_sl());
      end
      n_cmp++;
      if (stall_count !== 16'(mcnt) || s_stall_count !== 3'(mcnt_sat)) begin
        n_fail++;
        $display("FAIL rand_count cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_count, s_stall_count, mcnt, mcnt_sat);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_alu_branch();
    test_load();
    test_r0_unused();
    test_flush_waw();
    test_stall_ignores_issue();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
